// File: rtl/multicycle_control.sv
// multicycle_control
//   Multi-cycle MIPS main control. Steps each instruction through
//   FETCH -> DECODE -> EXEC [-> MEM] [-> WB] so that one ALU and one unified
//   memory are shared across cycles. It drives the datapath muxes, PC,
//   register file and memory strobes, and counts retired instructions.
//
//   Optional build macro: MULTICYCLE_ILLEGAL_TRAP_EN
//     defined   - an unknown opcode in EXEC locks the FSM in TRAP until reset
//     undefined - an unknown opcode executes as a NOP and retires
//
// Parameters
//   ALUOP_W  width of alu_op (>= 3, bits above [2:0] are driven 0)
//   CNT_W    width of instr_count
//
// Ports
//   clk            system clock, rising edge
//   reset          synchronous active-high reset
//   opcode[5:0]    IR[31:26], sampled only in DECODE
//   mem_ready      memory completes the current access this cycle
//   pc_write       unconditional PC load
//   pc_write_cond  PC load qualified by the branch compare
//   pc_op[1:0]     PC source: 00 ALU, 01 beq, 10 jump, 11 bne
//   i_or_d         memory address: 0 PC, 1 ALU out
//   mem_read       memory read strobe
//   mem_write      memory write strobe
//   ir_write       IR load
//   mem_to_reg     write-back data: 1 MDR, 0 ALU out
//   reg_dst[1:0]   write register: 00 rt, 01 rd, 10 $31
//   reg_write      register-file write enable
//   alu_src_a      ALU A: 0 PC, 1 rs
//   alu_src_b[1:0] ALU B: 00 rt, 01 4, 10 sext imm, 11 imm<<2
//   alu_op         ALU operation class
//   is_jal         selects PC+4 as write data
//   state[2:0]     current state (debug)
//   instr_count    retired-instruction count, wraps silently
module multicycle_control #(
   parameter int ALUOP_W = 3,
   parameter int CNT_W   = 32
) (
   input  logic               clk,
   input  logic               reset,
   input  logic [5:0]         opcode,
   input  logic               mem_ready,
   output logic               pc_write,
   output logic               pc_write_cond,
   output logic [1:0]         pc_op,
   output logic               i_or_d,
   output logic               mem_read,
   output logic               mem_write,
   output logic               ir_write,
   output logic               mem_to_reg,
   output logic [1:0]         reg_dst,
   output logic               reg_write,
   output logic               alu_src_a,
   output logic [1:0]         alu_src_b,
   output logic [ALUOP_W-1:0] alu_op,
   output logic               is_jal,
   output logic [2:0]         state,
   output logic [CNT_W-1:0]   instr_count
);

   typedef enum logic [2:0] {
      S_FETCH  = 3'd0,
      S_DECODE = 3'd1,
      S_EXEC   = 3'd2,
      S_MEM    = 3'd3,
      S_WB     = 3'd4,
      S_TRAP   = 3'd7
   } state_t;

   localparam logic [5:0] OP_RTYPE = 6'b000000;
   localparam logic [5:0] OP_J     = 6'b000010;
   localparam logic [5:0] OP_JAL   = 6'b000011;
   localparam logic [5:0] OP_BEQ   = 6'b000100;
   localparam logic [5:0] OP_BNE   = 6'b000101;
   localparam logic [5:0] OP_ADDI  = 6'b001000;
   localparam logic [5:0] OP_SLTI  = 6'b001010;
   localparam logic [5:0] OP_ANDI  = 6'b001100;
   localparam logic [5:0] OP_ORI   = 6'b001101;
   localparam logic [5:0] OP_XORI  = 6'b001110;
   localparam logic [5:0] OP_LUI   = 6'b001111;
   localparam logic [5:0] OP_LW    = 6'b100011;
   localparam logic [5:0] OP_SW    = 6'b101011;

   state_t           state_q, state_d;
   logic [5:0]       op_q;
   logic [CNT_W-1:0] count_q;
   logic             retire;
   logic [2:0]       alu_cls;

   assign state       = state_q;
   assign instr_count = count_q;
   assign alu_op      = ALUOP_W'(alu_cls);

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= S_FETCH;
         op_q    <= 6'd0;
         count_q <= '0;
      end else begin
         state_q <= state_d;
         if (state_q == S_DECODE) op_q <= opcode;
         if (retire) count_q <= count_q + CNT_W'(1);
      end
   end

   always_comb begin
      state_d       = state_q;
      retire        = 1'b0;
      pc_write      = 1'b0;
      pc_write_cond = 1'b0;
      pc_op         = 2'b00;
      i_or_d        = 1'b0;
      mem_read      = 1'b0;
      mem_write     = 1'b0;
      ir_write      = 1'b0;
      mem_to_reg    = 1'b0;
      reg_dst       = 2'b00;
      reg_write     = 1'b0;
      alu_src_a     = 1'b0;
      alu_src_b     = 2'b00;
      alu_cls       = 3'b000;
      is_jal        = 1'b0;
      case (state_q)
         S_FETCH: begin
            // ALU computes PC+4 while memory returns the instruction
            mem_read  = 1'b1;
            alu_src_b = 2'b01;
            if (mem_ready) begin
               ir_write = 1'b1;
               pc_write = 1'b1;
               state_d  = S_DECODE;
            end
         end
         S_DECODE: begin
            // speculative branch target PC + (imm<<2)
            alu_src_b = 2'b11;
            state_d   = S_EXEC;
         end
         S_EXEC: begin
            case (op_q)
               OP_RTYPE: begin
                  alu_src_a = 1'b1;
                  alu_cls   = 3'b010;
                  state_d   = S_WB;
               end
               OP_ADDI, OP_SLTI, OP_ANDI, OP_ORI, OP_XORI, OP_LUI: begin
                  alu_src_a = 1'b1;
                  alu_src_b = 2'b10;
                  case (op_q)
                     OP_SLTI: alu_cls = 3'b011;
                     OP_ANDI: alu_cls = 3'b100;
                     OP_ORI:  alu_cls = 3'b101;
                     OP_XORI: alu_cls = 3'b110;
                     OP_LUI:  alu_cls = 3'b111;
                     default: alu_cls = 3'b000;
                  endcase
                  state_d = S_WB;
               end
               OP_LW, OP_SW: begin
                  alu_src_a = 1'b1;
                  alu_src_b = 2'b10;
                  state_d   = S_MEM;
               end
               OP_BEQ, OP_BNE: begin
                  alu_src_a     = 1'b1;
                  alu_cls       = 3'b001;
                  pc_write_cond = 1'b1;
                  pc_op         = (op_q == OP_BNE) ? 2'b11 : 2'b01;
                  state_d       = S_FETCH;
                  retire        = 1'b1;
               end
               OP_J, OP_JAL: begin
                  pc_write = 1'b1;
                  pc_op    = 2'b10;
                  if (op_q == OP_JAL) begin
                     reg_write = 1'b1;
                     reg_dst   = 2'b10;
                     is_jal    = 1'b1;
                  end
                  state_d = S_FETCH;
                  retire  = 1'b1;
               end
               default: begin
`ifdef MULTICYCLE_ILLEGAL_TRAP_EN
                  state_d = S_TRAP;
`else
                  // unknown opcode behaves as a NOP and still retires
                  state_d = S_FETCH;
                  retire  = 1'b1;
`endif
               end
            endcase
         end
         S_MEM: begin
            // strobes stay asserted through the wait; reset drops the access
            i_or_d    = 1'b1;
            mem_read  = (op_q == OP_LW);
            mem_write = (op_q == OP_SW);
            if (mem_ready) begin
               if (op_q == OP_LW) begin
                  state_d = S_WB;
               end else begin
                  state_d = S_FETCH;
                  retire  = 1'b1;
               end
            end
         end
         S_WB: begin
            reg_write = 1'b1;
            if (op_q == OP_RTYPE) reg_dst = 2'b01;
            if (op_q == OP_LW) mem_to_reg = 1'b1;
            state_d = S_FETCH;
            retire  = 1'b1;
         end
         S_TRAP: begin
            state_d = S_TRAP;
         end
         default: begin
            state_d = S_FETCH;
         end
      endcase
   end

endmodule

// File: tb/tb_multicycle_control.sv
// tb_multicycle_control
//   Directed-vector bench for multicycle_control. A second instance with a
//   2-bit counter shares the stimulus so counter wrap can be observed.
//   Honours MULTICYCLE_ILLEGAL_TRAP_EN for the unknown-opcode expectations.
module tb_multicycle_control;

   logic        clk = 1'b0;
   logic        reset;
   logic [5:0]  opcode;
   logic        mem_ready;

   logic        pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write;
   logic        mem_to_reg, reg_write, alu_src_a, is_jal;
   logic [1:0]  pc_op, reg_dst, alu_src_b;
   logic [2:0]  alu_op, state;
   logic [31:0] instr_count;

   logic        s_pc_write, s_pc_write_cond, s_i_or_d, s_mem_read, s_mem_write;
   logic        s_ir_write, s_mem_to_reg, s_reg_write, s_alu_src_a, s_is_jal;
   logic [1:0]  s_pc_op, s_reg_dst, s_alu_src_b;
   logic [2:0]  s_alu_op, s_state;
   logic [1:0]  s_instr_count;

   int n_vec  = 0;
   int n_miss = 0;

   multicycle_control #(.ALUOP_W(3), .CNT_W(32)) dut (
      .clk(clk), .reset(reset), .opcode(opcode), .mem_ready(mem_ready),
      .pc_write(pc_write), .pc_write_cond(pc_write_cond), .pc_op(pc_op),
      .i_or_d(i_or_d), .mem_read(mem_read), .mem_write(mem_write),
      .ir_write(ir_write), .mem_to_reg(mem_to_reg), .reg_dst(reg_dst),
      .reg_write(reg_write), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b),
      .alu_op(alu_op), .is_jal(is_jal), .state(state),
      .instr_count(instr_count)
   );

   multicycle_control #(.ALUOP_W(3), .CNT_W(2)) dut_small (
      .clk(clk), .reset(reset), .opcode(opcode), .mem_ready(mem_ready),
      .pc_write(s_pc_write), .pc_write_cond(s_pc_write_cond), .pc_op(s_pc_op),
      .i_or_d(s_i_or_d), .mem_read(s_mem_read), .mem_write(s_mem_write),
      .ir_write(s_ir_write), .mem_to_reg(s_mem_to_reg), .reg_dst(s_reg_dst),
      .reg_write(s_reg_write), .alu_src_a(s_alu_src_a), .alu_src_b(s_alu_src_b),
      .alu_op(s_alu_op), .is_jal(s_is_jal), .state(s_state),
      .instr_count(s_instr_count)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_miss++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // advance one clock, land mid-cycle well clear of the edge
   task automatic cyc;
      @(posedge clk);
      #2;
   endtask

   // one j from FETCH back to FETCH (3 cycles)
   task automatic run_j;
      opcode = 6'b000010;
      cyc; cyc; cyc;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "timeout");
   end

   initial begin
      reset     = 1'b1;
      mem_ready = 1'b1;
      opcode    = 6'b000000;
      repeat (2) @(posedge clk);
      #1 reset = 1'b0;
      #1;
      // reset state
      chk("rst_state", state, 0);
      chk("rst_mem_read", mem_read, 1);
      chk("rst_ir_write", ir_write, 1);
      chk("rst_pc_write", pc_write, 1);
      chk("rst_alu_src_b", alu_src_b, 2'b01);
      chk("rst_count", instr_count, 0);

      // R-type
      opcode = 6'b000000;
      cyc; chk("r_dec_state", state, 1);
      chk("r_dec_alu_src_b", alu_src_b, 2'b11);
      cyc; chk("r_exe_state", state, 2);
      chk("r_exe_alu_op", alu_op, 3'b010);
      chk("r_exe_alu_src_b", alu_src_b, 2'b00);
      chk("r_exe_alu_src_a", alu_src_a, 1);
      cyc; chk("r_wb_state", state, 4);
      chk("r_wb_reg_dst", reg_dst, 2'b01);
      chk("r_wb_reg_write", reg_write, 1);
      chk("r_wb_mem_to_reg", mem_to_reg, 0);
      cyc; chk("r_end_state", state, 0);
      chk("r_count", instr_count, 1);

      // lw with two memory wait cycles
      opcode = 6'b100011;
      cyc; cyc; chk("lw_exe_alu_src_b", alu_src_b, 2'b10);
      cyc; mem_ready = 1'b0; #1;
      chk("lw_mem1_state", state, 3);
      chk("lw_mem1_mem_read", mem_read, 1);
      chk("lw_mem1_i_or_d", i_or_d, 1);
      chk("lw_mem1_mem_write", mem_write, 0);
      cyc; chk("lw_mem2_state", state, 3);
      cyc; chk("lw_mem3_state", state, 3);
      chk("lw_mem3_mem_read", mem_read, 1);
      mem_ready = 1'b1;
      cyc; chk("lw_wb_state", state, 4);
      chk("lw_wb_mem_to_reg", mem_to_reg, 1);
      chk("lw_wb_reg_dst", reg_dst, 2'b00);
      chk("lw_wb_reg_write", reg_write, 1);
      chk("lw_count_pre", instr_count, 1);
      cyc; chk("lw_end_state", state, 0);
      chk("lw_count", instr_count, 2);

      // jal
      opcode = 6'b000011;
      cyc; cyc;
      chk("jal_exe_pc_write", pc_write, 1);
      chk("jal_exe_pc_op", pc_op, 2'b10);
      chk("jal_exe_reg_dst", reg_dst, 2'b10);
      chk("jal_exe_is_jal", is_jal, 1);
      chk("jal_exe_reg_write", reg_write, 1);
      cyc; chk("jal_end_state", state, 0);
      chk("jal_count", instr_count, 3);

      // sw interrupted by reset while waiting in MEM
      opcode = 6'b101011;
      cyc; cyc; cyc;
      mem_ready = 1'b0; #1;
      chk("sw_mem_state", state, 3);
      chk("sw_mem_write", mem_write, 1);
      chk("sw_mem_read", mem_read, 0);
      reset = 1'b1;
      cyc; reset = 1'b0; #1;
      chk("sw_rst_state", state, 0);
      chk("sw_rst_mem_write", mem_write, 0);
      chk("sw_rst_count", instr_count, 0);
      // FETCH holds while memory is not ready
      chk("fetch_wait_ir_write", ir_write, 0);
      chk("fetch_wait_pc_write", pc_write, 0);
      cyc; chk("fetch_wait_state", state, 0);
      mem_ready = 1'b1;

      // ori
      opcode = 6'b001101;
      cyc; cyc;
      chk("ori_exe_alu_op", alu_op, 3'b101);
      chk("ori_exe_alu_src_b", alu_src_b, 2'b10);
      cyc; chk("ori_wb_reg_dst", reg_dst, 2'b00);
      chk("ori_wb_reg_write", reg_write, 1);
      cyc; chk("ori_count", instr_count, 1);

      // beq / bne
      opcode = 6'b000100;
      cyc; cyc;
      chk("beq_pc_write_cond", pc_write_cond, 1);
      chk("beq_pc_op", pc_op, 2'b01);
      chk("beq_alu_op", alu_op, 3'b001);
      chk("beq_pc_write", pc_write, 0);
      cyc; chk("beq_end_state", state, 0);
      chk("beq_count", instr_count, 2);
      opcode = 6'b000101;
      cyc; cyc;
      chk("bne_pc_op", pc_op, 2'b11);
      chk("bne_pc_write_cond", pc_write_cond, 1);
      cyc; chk("bne_count", instr_count, 3);

      // unknown opcode
      opcode = 6'b111111;
      cyc; cyc;
      chk("ill_exe_pc_write", pc_write, 0);
      chk("ill_exe_reg_write", reg_write, 0);
      chk("ill_exe_alu_src_a", alu_src_a, 0);
      cyc;
`ifdef MULTICYCLE_ILLEGAL_TRAP_EN
      chk("ill_trap_state", state, 7);
      chk("ill_trap_mem_read", mem_read, 0);
      chk("ill_trap_alu_src_b", alu_src_b, 0);
      repeat (10) cyc;
      chk("ill_trap_hold", state, 7);
      chk("ill_trap_count", instr_count, 3);
`else
      chk("ill_nop_state", state, 0);
      chk("ill_nop_count", instr_count, 4);
`endif

      // counter wrap on the 2-bit instance
      reset = 1'b1;
      cyc; reset = 1'b0; #1;
      chk("wrap_rst_count", s_instr_count, 0);
      run_j; run_j; run_j;
      chk("wrap_full", s_instr_count, 3);
      run_j;
      chk("wrap_zero", s_instr_count, 0);
      chk("wrap_main_count", instr_count, 4);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end

endmodule
